// File: rtl/adder8b_pkg.sv
// ---------------------------------------------------------------------------
// adder8b_pkg
//   Shared constants and vector types for the 8-bit ripple-carry adder.
//   ADDER_WIDTH : operand width in bits
//   operand_t   : one operand vector (ADDER_WIDTH bits)
//   sum_t       : full sum vector including carry-out (ADDER_WIDTH+1 bits)
// ---------------------------------------------------------------------------
package adder8b_pkg;

    localparam int ADDER_WIDTH = 8;

    typedef logic [ADDER_WIDTH-1:0] operand_t;
    typedef logic [ADDER_WIDTH:0]   sum_t;

endpackage : adder8b_pkg

// File: rtl/adder8b_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit full-adder cell, the building block of the ripple chain.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in from the next-lower cell
//     s     : sum bit
//     cout  : carry out to the next-higher cell
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the parity of the three inputs; carry is their majority vote.
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/adder8b.sv
// ---------------------------------------------------------------------------
// adder8b
//   Unsigned WIDTH-bit adder built as a structural ripple-carry chain of
//   full_adder cells. Offers the sum combinationally (S) and as a one-cycle
//   registered copy (S_q) for pipelined datapaths.
//   Ports:
//     clk   : rising-edge clock for S_q
//     rst_n : asynchronous active-low reset, clears S_q only
//     A, B  : unsigned operands (WIDTH bits)
//     S     : combinational sum, S[WIDTH] is the carry-out
//     S_q   : registered copy of S, one cycle latency, no enable
// ---------------------------------------------------------------------------
module adder8b
    import adder8b_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   S,
    output logic [WIDTH:0]   S_q
);

    // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    // The chain starts with no incoming carry.
    assign carry[0] = 1'b0;

    // One full-adder cell per bit, each feeding its carry to the next cell up.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    // The top cell's carry-out becomes the extra sum bit, so no overflow is lost.
    assign S = {carry[WIDTH], sum_bits};

    // Output register: cleared as soon as reset asserts, otherwise samples the
    // combinational sum on every rising edge. The combinational S is untouched
    // by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q <= '0;
        end else begin
            S_q <= S;
        end
    end

endmodule : adder8b

// File: tb/tb_adder8b.sv
// ---------------------------------------------------------------------------
// tb_adder8b
//   Self-checking bench for adder8b: directed vectors with hand-computed
//   expected sums, an exhaustive combinational sweep, registered-path and
//   async-reset checks, and a random commutativity spot check.
// ---------------------------------------------------------------------------
module tb_adder8b;

    import adder8b_pkg::*;

    logic     clk;
    logic     rst_n;
    operand_t A;
    operand_t B;
    sum_t     S;
    sum_t     S_q;

    int numVectors;
    int numMiscompares;

    adder8b #(
        .WIDTH (ADDER_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S     (S),
        .S_q   (S_q)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive both operands and give the combinational sum a moment to settle.
    task automatic applyStimulus(input operand_t a, input operand_t b);
        A = a;
        B = b;
        #1;
    endtask

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input sum_t observed, input sum_t expected);
        numVectors++;
        if (observed !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 9'h%03h, expected 9'h%03h (A=%02h B=%02h) at %0t",
                     tag, observed, expected, A, B, $time);
        end
    endtask

    // Directed corner and carry-ripple vectors with hand-computed sums.
    localparam int NUM_DIRECTED = 6;
    operand_t dirA   [NUM_DIRECTED] = '{8'h00, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h55};
    operand_t dirB   [NUM_DIRECTED] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h01, 8'hAA};
    sum_t     dirSum [NUM_DIRECTED] = '{9'h000, 9'h100, 9'h1FE, 9'h100, 9'h080, 9'h0FF};

    // Main sequence: reset, combinational checks, registered path, async reset.
    initial begin
        sum_t     expSum;
        operand_t ra;
        operand_t rb;

        numVectors     = 0;
        numMiscompares = 0;
        rst_n          = 1'b1;
        A              = '0;
        B              = '0;

        // Assert reset between edges; S_q must clear while S keeps adding.
        #2;
        rst_n = 1'b0;
        applyStimulus(8'h03, 8'h04);
        checkOutput("reset_sq", S_q, 9'h000);
        checkOutput("reset_s", S, 9'h007);
        @(posedge clk);
        #1;
        checkOutput("reset_held", S_q, 9'h000);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NUM_DIRECTED; i++) begin
            applyStimulus(dirA[i], dirB[i]);
            checkOutput("directed", S, dirSum[i]);
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                applyStimulus(operand_t'(a), operand_t'(b));
                expSum = sum_t'(a + b);
                checkOutput("sweep", S, expSum);
            end
        end

        // Registered path: one-cycle latency and stable between edges.
        @(negedge clk);
        applyStimulus(8'h12, 8'h34);
        @(posedge clk);
        #1;
        checkOutput("reg_load", S_q, 9'h046);
        applyStimulus(8'h20, 8'h01);
        checkOutput("reg_hold_s", S, 9'h021);
        checkOutput("reg_hold", S_q, 9'h046);
        @(negedge clk);
        checkOutput("reg_hold_neg", S_q, 9'h046);
        @(posedge clk);
        #1;
        checkOutput("reg_next", S_q, 9'h021);

        // Async reset mid-operation with the register holding 1FE.
        @(negedge clk);
        applyStimulus(8'hFF, 8'hFF);
        @(posedge clk);
        #1;
        checkOutput("pre_reset", S_q, 9'h1FE);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_clear", S_q, 9'h000);
        checkOutput("async_s", S, 9'h1FE);
        @(posedge clk);
        #1;
        checkOutput("async_held", S_q, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h01, 8'h02);
        checkOutput("release_wait", S_q, 9'h000);
        @(posedge clk);
        #1;
        checkOutput("release_load", S_q, 9'h003);

        // Commutativity: both orders must give the exact 9-bit sum.
        for (int n = 0; n < 1000; n++) begin
            ra     = operand_t'($urandom_range(0, 255));
            rb     = operand_t'($urandom_range(0, 255));
            expSum = sum_t'(int'(ra) + int'(rb));
            applyStimulus(ra, rb);
            checkOutput("commute_ab", S, expSum);
            applyStimulus(rb, ra);
            checkOutput("commute_ba", S, expSum);
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule : tb_adder8b

// File: doc/adder8b.md
Name: adder8b

Overview:
- Unsigned 8-bit adder with a full 9-bit sum (carry into bit 8), built as a structural ripple-carry chain of full-adder cells.
- Provides two views of the result: a combinational sum for same-cycle use, and a registered copy for pipelined datapaths.
- Sits in the arithmetic datapath as a leaf block; no handshake and no internal state beyond the output register.

Parameters:
- WIDTH, 8, operand width in bits; sum width is WIDTH+1. Only 8 is required to be verified; the RTL must stay generic.

Ports:
- clk  input  1  rising-edge clock for the registered sum
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  unsigned operand A
- B  input  WIDTH  unsigned operand B
- S  output  WIDTH+1  combinational sum A+B; S[WIDTH] is the carry-out
- S_q  output  WIDTH+1  registered copy of S

Behaviour:
- Interface (decided): one clock; reset is asynchronous and active-low.
- S = zero-extended A + zero-extended B, exact. No overflow is possible: max 255+255 = 510 = 9'b1_1111_1110.
- S is purely combinational.
  - Settles within the same delta/time step as an input change.
  - Independent of clk and rst_n.
  - Never X when A and B are known.
- S_q captures S on every rising clk edge. Latency is 1 cycle; no enable.
- rst_n low forces S_q to 0 immediately, regardless of clk. S_q is held at 0 while rst_n is low.
- After rst_n deasserts, the first rising edge loads the current S.
- Reset has no effect on S.
- Implementation is a ripple chain:
  - Carry-in of bit 0 is tied to 0.
  - Carry-out of bit i feeds bit i+1.
  - S[WIDTH] is the carry-out of the top cell.
  - No behavioural "+" is used for S.
- X/Z on any operand bit may propagate to S; a bench must drive known values.

Decomposition:
- Shared package: constant ADDER_WIDTH = 8; typedefs for the operand vector (ADDER_WIDTH bits) and the sum vector (ADDER_WIDTH+1 bits).
- One natural sub-module: full_adder.
  - Inputs a, b, cin; outputs s, cout.
  - s = a^b^cin; cout = majority(a, b, cin).
- adder8b instantiates WIDTH full_adder cells via a generate loop and adds the output register.

Test Plan:
- Exhaustive combinational sweep: all 65536 (A,B) pairs with a #1 settle each -> S == A+B computed at 9 bits; the error count must be 0.
- Corner values: A=0,B=0 -> S=0; A=8'hFF,B=8'h01 -> S=9'h100; A=8'hFF,B=8'hFF -> S=9'h1FE; A=8'h80,B=8'h80 -> S=9'h100.
- Full carry ripple: A=8'h7F,B=8'h01 -> S=9'h080; A=8'h55,B=8'hAA -> S=9'h0FF, with no carry.
- Registered path: with rst_n high, apply A=8'h12,B=8'h34 before an edge -> S_q=9'h046 after that edge; S_q is unchanged between edges even if A/B change.
- Async reset mid-operation: with S_q=9'h1FE, drop rst_n between edges -> S_q=0 immediately while S still shows the current sum; release rst_n -> S_q loads S at the next rising edge.
- Commutativity spot check: for 1000 random pairs, S(A,B) == S(B,A).
